// File: rtl/sprite_pixel_pipe_pkg.sv
// Shared widths, types and the palette lookup for the sprite pixel pipe.
//   COORD_W  raster / sprite / mouse coordinate width
//   SPR_BITS log2 of the sprite edge; the bitmap RAM address is {dy,dx}
//   DATA_W   colour index width, index 0 is transparent
//   RGB_W    output colour width
package sprite_pixel_pipe_pkg;

  localparam int COORD_W  = 11;
  localparam int SPR_BITS = 5;
  localparam int DATA_W   = 2;
  localparam int RGB_W    = 12;
  localparam int ADDR_W   = 2 * SPR_BITS;
  localparam int SPR_DIM  = 1 << SPR_BITS;

  typedef logic [DATA_W-1:0] color_idx_t;

  localparam color_idx_t TRANSPARENT = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SCAN  = 2'd2
  } hit_state_t;

  function automatic logic [RGB_W-1:0] pal_lookup(
    input color_idx_t       idx,
    input logic [RGB_W-1:0] p1,
    input logic [RGB_W-1:0] p2,
    input logic [RGB_W-1:0] p3
  );
    case (idx)
      2'd1:    return p1;
      2'd2:    return p2;
      2'd3:    return p3;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/sprite_pixel_pipe_if.sv
// Read port of the 32x32 sprite bitmap RAM.
//   ram_addr  registered read address {dy,dx}, driven by the pixel pipe
//   ram_data  colour index, valid the cycle after ram_addr
interface sprite_pixel_pipe_if;
  import sprite_pixel_pipe_pkg::*;

  logic [ADDR_W-1:0] ram_addr;
  color_idx_t        ram_data;

  modport master (output ram_addr, input ram_data);
  modport slave  (input ram_addr, output ram_data);
endinterface

// File: rtl/sprite_pixel_pipe_hit_fsm.sv
// Mouse click resolver: latches an accepted click, waits for the next
// frame, watches that whole frame for an opaque sprite pixel at the mouse
// position and reports hit or miss at the frame_start that ends it.
//   clk, reset_n         clock, synchronous active-low reset
//   click_i              1-cycle click pulse
//   frame_start_i        1-cycle frame boundary pulse
//   mouse_x_i/mouse_y_i  mouse position, latched on an accepted click
//   scan_hit_i           S3 pixel is the mouse pixel and is opaque
//   mx_o/my_o            latched mouse position
//   hit_o/miss_o         1-cycle result pulses
//
//   state | meaning
//   IDLE  | no click pending; a click is accepted here
//   ARMED | click latched, waiting for the start of a full frame
//   SCAN  | frame being scanned; result reported at next frame_start
module sprite_hit_fsm
  import sprite_pixel_pipe_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               click_i,
  input  logic               frame_start_i,
  input  logic [COORD_W-1:0] mouse_x_i,
  input  logic [COORD_W-1:0] mouse_y_i,
  input  logic               scan_hit_i,
  output logic [COORD_W-1:0] mx_o,
  output logic [COORD_W-1:0] my_o,
  output logic               hit_o,
  output logic               miss_o
);

  hit_state_t         state_q;
  logic [COORD_W-1:0] mx_q, my_q;
  logic               hit_seen_q, hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mx_q       <= '0;
      my_q       <= '0;
      hit_seen_q <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        // A click coinciding with frame_start only arms; scanning starts at
        // the following frame so a partial frame is never judged.
        IDLE: if (click_i) begin
          mx_q    <= mouse_x_i;
          my_q    <= mouse_y_i;
          state_q <= ARMED;
        end
        ARMED: if (frame_start_i) begin
          hit_seen_q <= 1'b0;
          state_q    <= SCAN;
        end
        SCAN: begin
          if (scan_hit_i) hit_seen_q <= 1'b1;
          if (frame_start_i) begin
            hit_q   <= hit_seen_q;
            miss_q  <= !hit_seen_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mx_o   = mx_q;
  assign my_o   = my_q;
  assign hit_o  = hit_q;
  assign miss_o = miss_q;

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Sprite pixel pipeline: maps raster (x,y) to a bitmap RAM address, realigns
// the RAM data, applies the palette and resolves mouse clicks.
// Latency from (x,y) to rgb/sprite_on is 3 cycles.
//   clk, reset_n          clock, synchronous active-low reset
//   x_i, y_i              raster pixel, valid every cycle
//   frame_start_i         frame boundary pulse (vertical blanking)
//   spr_x_i, spr_y_i      sprite top-left, taken only on frame_start_i
//   pal1_i..pal3_i        colours for indices 1..3
//   ram_if                bitmap RAM read port (master)
//   click_i               mouse click pulse
//   mouse_x_i, mouse_y_i  mouse position
//   rgb_o, sprite_on_o    pixel colour and opaque-sprite flag
//   hit_o, miss_o         click result pulses
module sprite_pixel_pipe
  import sprite_pixel_pipe_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic               frame_start_i,
  input  logic [COORD_W-1:0] spr_x_i,
  input  logic [COORD_W-1:0] spr_y_i,
  input  logic [RGB_W-1:0]   pal1_i,
  input  logic [RGB_W-1:0]   pal2_i,
  input  logic [RGB_W-1:0]   pal3_i,
  sprite_pixel_pipe_if.master ram_if,
  input  logic               click_i,
  input  logic [COORD_W-1:0] mouse_x_i,
  input  logic [COORD_W-1:0] mouse_y_i,
  output logic [RGB_W-1:0]   rgb_o,
  output logic               sprite_on_o,
  output logic               hit_o,
  output logic               miss_o
);

  logic [COORD_W-1:0] sx_q, sy_q;
  logic [COORD_W-1:0] mx, my;
  logic [COORD_W:0]   dx_d, dy_d;
  logic               in_box_d, m_tag_d, opaque_d;
  logic [ADDR_W-1:0]  ram_addr_d, ram_addr_q;
  logic               in_box1_q, in_box2_q;
  logic               m1_q, m2_q, m3_q;
  logic [RGB_W-1:0]   rgb_d, rgb_q;
  logic               sprite_on_q;

  // The extra top bit of dx/dy is the borrow: a pixel left of or above the
  // sprite gives a nonzero upper slice, so coordinates never wrap into it.
  always_comb begin
    dx_d       = {1'b0, x_i} - {1'b0, sx_q};
    dy_d       = {1'b0, y_i} - {1'b0, sy_q};
    in_box_d   = (dx_d[COORD_W:SPR_BITS] == '0) && (dy_d[COORD_W:SPR_BITS] == '0);
    ram_addr_d = in_box_d ? {dy_d[SPR_BITS-1:0], dx_d[SPR_BITS-1:0]} : ram_addr_q;
    m_tag_d    = (x_i == mx) && (y_i == my);
    opaque_d   = in_box2_q && (ram_if.ram_data != TRANSPARENT);
    rgb_d      = opaque_d ? pal_lookup(ram_if.ram_data, pal1_i, pal2_i, pal3_i) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      ram_addr_q  <= '0;
      in_box1_q   <= 1'b0;
      in_box2_q   <= 1'b0;
      m1_q        <= 1'b0;
      m2_q        <= 1'b0;
      m3_q        <= 1'b0;
      rgb_q       <= '0;
      sprite_on_q <= 1'b0;
    end else begin
      if (frame_start_i) begin
        sx_q <= spr_x_i;
        sy_q <= spr_y_i;
      end
      ram_addr_q  <= ram_addr_d;
      in_box1_q   <= in_box_d;
      m1_q        <= m_tag_d;
      in_box2_q   <= in_box1_q;
      m2_q        <= m1_q;
      sprite_on_q <= opaque_d;
      rgb_q       <= rgb_d;
      m3_q        <= m2_q;
    end
  end

  sprite_hit_fsm u_hit_fsm (
    .clk           (clk),
    .reset_n       (reset_n),
    .click_i       (click_i),
    .frame_start_i (frame_start_i),
    .mouse_x_i     (mouse_x_i),
    .mouse_y_i     (mouse_y_i),
    .scan_hit_i    (m3_q && sprite_on_q),
    .mx_o          (mx),
    .my_o          (my),
    .hit_o         (hit_o),
    .miss_o        (miss_o)
  );

  assign ram_if.ram_addr = ram_addr_q;
  assign rgb_o           = rgb_q;
  assign sprite_on_o     = sprite_on_q;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
module tb_sprite_pixel_pipe;
  import sprite_pixel_pipe_pkg::*;

  localparam int XMAX = 1 << COORD_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic [COORD_W-1:0] x, y, spr_x, spr_y, mouse_x, mouse_y;
  logic               frame_start, click;
  logic [RGB_W-1:0]   pal1, pal2, pal3, rgb;
  logic               sprite_on, hit, miss;

  sprite_pixel_pipe_if ram_if();

  sprite_pixel_pipe dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .x_i           (x),
    .y_i           (y),
    .frame_start_i (frame_start),
    .spr_x_i       (spr_x),
    .spr_y_i       (spr_y),
    .pal1_i        (pal1),
    .pal2_i        (pal2),
    .pal3_i        (pal3),
    .ram_if        (ram_if),
    .click_i       (click),
    .mouse_x_i     (mouse_x),
    .mouse_y_i     (mouse_y),
    .rgb_o         (rgb),
    .sprite_on_o   (sprite_on),
    .hit_o         (hit),
    .miss_o        (miss)
  );

  // bitmap RAM with one cycle of read latency
  logic [DATA_W-1:0] mem [0:SPR_DIM*SPR_DIM-1];
  always @(posedge clk) ram_if.ram_data <= mem[ram_if.ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [ADDR_W-1:0] addr; } addr_exp_t;
  typedef struct { int due; logic [RGB_W-1:0] rgb; logic on; } pix_exp_t;
  typedef struct { int due; logic hit; logic miss; } hm_exp_t;

  addr_exp_t aq[$];
  pix_exp_t  pq[$];
  hm_exp_t   hq[$];

  int checks = 0;
  int fails  = 0;

  // reference state: latched sprite position, last in-box address,
  // pending click (0 none, 1 waiting for a full frame, 2 frame being judged)
  int              m_sx, m_sy;
  logic [ADDR_W-1:0] m_last_addr;
  int              phase, pmx, pmy;
  bit              p_res;
  int              fr_x0, fr_y0, fr_w, fr_h;

  function automatic logic [RGB_W-1:0] pal_of(input logic [DATA_W-1:0] idx);
    if (idx == 1) return pal1;
    if (idx == 2) return pal2;
    if (idx == 3) return pal3;
    return '0;
  endfunction

  // The scanned frame contains the mouse pixel, and that pixel lies on an
  // opaque texel of the sprite at the position used for the frame.
  function automatic bit judge();
    int dxr, ddx, ddy;
    dxr = (pmx - fr_x0 + XMAX) % XMAX;
    if (!(dxr < fr_w && pmy >= fr_y0 && pmy < fr_y0 + fr_h)) return 1'b0;
    ddx = pmx - m_sx;
    ddy = pmy - m_sy;
    if (ddx < 0 || ddx >= SPR_DIM || ddy < 0 || ddy >= SPR_DIM) return 1'b0;
    return mem[ddy*SPR_DIM + ddx] != 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input int px, input int py, input bit fs, input bit ck,
                             input int cmx, input int cmy);
    int dx, dy, a;
    addr_exp_t ae;
    pix_exp_t  pe;
    hm_exp_t   he;
    bit acc;
    x = COORD_W'(px); y = COORD_W'(py); frame_start = fs; click = ck;
    mouse_x = COORD_W'(cmx); mouse_y = COORD_W'(cmy);
    dx = px - m_sx;
    dy = py - m_sy;
    pe.rgb = '0; pe.on = 1'b0;
    if (dx >= 0 && dx < SPR_DIM && dy >= 0 && dy < SPR_DIM) begin
      a = dy*SPR_DIM + dx;
      m_last_addr = ADDR_W'(a);
      if (mem[a] != 0) begin pe.on = 1'b1; pe.rgb = pal_of(mem[a]); end
    end
    ae.due = cyc + 1; ae.addr = m_last_addr; aq.push_back(ae);
    pe.due = cyc + 3; pq.push_back(pe);
    acc = 1'b0;
    if (ck && phase == 0) begin phase = 1; pmx = cmx; pmy = cmy; acc = 1'b1; end
    if (fs) begin
      m_sx = int'(spr_x);
      m_sy = int'(spr_y);
      if (phase == 2) begin
        he.due = cyc + 1; he.hit = p_res; he.miss = !p_res; hq.push_back(he);
        phase = 0;
      end else if (phase == 1 && !acc) begin
        phase = 2;
        p_res = judge();
      end
    end
    step();
  endtask

  task automatic do_reset(input int n);
    pix_exp_t  pe;
    addr_exp_t ae;
    reset_n = 1'b0;
    while (aq.size() > 0 && aq[$].due > cyc) ae = aq.pop_back();
    while (pq.size() > 0 && pq[$].due > cyc) pe = pq.pop_back();
    while (hq.size() > 0 && hq[$].due > cyc) void'(hq.pop_back());
    phase = 0; m_sx = 0; m_sy = 0; m_last_addr = '0;
    for (int i = 0; i < n; i++) begin
      x = COORD_W'($urandom); y = COORD_W'($urandom);
      frame_start = 1'b0; click = (i == 0);
      mouse_x = COORD_W'($urandom); mouse_y = COORD_W'($urandom);
      ae.due = cyc + 1; ae.addr = '0; aq.push_back(ae);
      pe.due = cyc + 1; pe.rgb = '0; pe.on = 1'b0; pq.push_back(pe);
      step();
    end
    reset_n = 1'b1;
    click = 1'b0;
    pe.due = cyc + 1; pq.push_back(pe);
    pe.due = cyc + 2; pq.push_back(pe);
  endtask

  task automatic run_frame(input int fx0, input int fy0, input int w, input int h,
                           input int sx, input int sy, input int mid_sx,
                           input int c1_idx, input int c1x, input int c1y,
                           input int c2_idx, input int c2x, input int c2y,
                           input bit cfs, input int rst_idx);
    int cx, cy;
    fr_x0 = fx0; fr_y0 = fy0; fr_w = w; fr_h = h;
    spr_x = COORD_W'(sx); spr_y = COORD_W'(sy);
    drive_cycle(XMAX-1, XMAX-1, 1'b1, cfs, c1x, c1y);
    drive_cycle(XMAX-1, XMAX-1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < w*h; i++) begin
      if (i == rst_idx) do_reset(3);
      if (i == (w*h)/2) spr_x = COORD_W'(mid_sx);
      cx = 0; cy = 0;
      if (i == c1_idx) begin cx = c1x; cy = c1y; end
      else if (i == c2_idx) begin cx = c2x; cy = c2y; end
      drive_cycle((fx0 + i % w) % XMAX, fy0 + i / w, 1'b0,
                  (i == c1_idx) || (i == c2_idx), cx, cy);
    end
    repeat (4) drive_cycle(XMAX-1, XMAX-1, 1'b0, 1'b0, 0, 0);
  endtask

  // monitor: compares whatever the scoreboard says is due this cycle
  always @(negedge clk) begin
    addr_exp_t ae;
    pix_exp_t  pe;
    hm_exp_t   he;
    if (cyc >= 1) begin
      while (aq.size() > 0 && aq[0].due < cyc) begin
        ae = aq.pop_front(); checks++; fails++;
        $display("FAIL ram_addr_missed due=%0d now=%0d", ae.due, cyc);
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
        ae = aq.pop_front(); checks++;
        if (ram_if.ram_addr !== ae.addr) begin
          fails++;
          $display("FAIL ram_addr cyc=%0d got=%0d exp=%0d", cyc, ram_if.ram_addr, ae.addr);
        end
      end
      while (pq.size() > 0 && pq[0].due < cyc) begin
        pe = pq.pop_front(); checks++; fails++;
        $display("FAIL pixel_missed due=%0d now=%0d", pe.due, cyc);
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        pe = pq.pop_front(); checks++;
        if (rgb !== pe.rgb || sprite_on !== pe.on) begin
          fails++;
          $display("FAIL pixel cyc=%0d got rgb=%03h on=%b exp rgb=%03h on=%b",
                   cyc, rgb, sprite_on, pe.rgb, pe.on);
        end
      end
      checks++;
      if (hq.size() > 0 && hq[0].due == cyc) begin
        he = hq.pop_front();
        if (hit !== he.hit || miss !== he.miss) begin
          fails++;
          $display("FAIL click_result cyc=%0d got hit=%b miss=%b exp hit=%b miss=%b",
                   cyc, hit, miss, he.hit, he.miss);
        end
      end else if (hit !== 1'b0 || miss !== 1'b0) begin
        fails++;
        $display("FAIL hit_miss_idle cyc=%0d got hit=%b miss=%b exp 0 0", cyc, hit, miss);
      end
      if (hq.size() > 0 && hq[0].due < cyc) begin
        he = hq.pop_front(); checks++; fails++;
        $display("FAIL click_result_missed due=%0d now=%0d", he.due, cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int fx0, fy0, sx, sy, mid, c1i, c2i, c1x, c1y, c2x, c2y;
    bit cfs;
    reset_n = 1'b0; x = '0; y = '0; frame_start = 1'b0; click = 1'b0;
    spr_x = '0; spr_y = '0; mouse_x = '0; mouse_y = '0;
    pal1 = 12'h00F; pal2 = 12'hF00; pal3 = 12'h0F0;
    m_sx = 0; m_sy = 0; m_last_addr = '0; phase = 0; pmx = 0; pmy = 0; p_res = 1'b0;
    fr_x0 = 0; fr_y0 = 0; fr_w = 0; fr_h = 0;
    for (int a = 0; a < SPR_DIM*SPR_DIM; a++) mem[a] = 2'd2;
    mem[234] = 2'd0;
    step();
    do_reset(3);

    // F1: sprite at (100,50); click on opaque (105,55); second click ignored
    run_frame(96, 48, 40, 11, 100, 50, 100, 289, 105, 55, 350, 110, 57, 1'b0, -1);
    // F2: scanned frame, spr_x moved mid-frame (must not take effect yet)
    run_frame(96, 48, 40, 11, 100, 50, 120, -1, 0, 0, -1, 0, 0, 1'b0, -1);
    // F3: move applied; hit reported; new click on transparent texel (110,57)
    run_frame(96, 48, 40, 11, 120, 50, 120, 350, 110, 57, -1, 0, 0, 1'b0, -1);
    // F4: scanned at (100,50): texel 234 is transparent -> miss next frame
    run_frame(96, 48, 40, 11, 100, 50, 100, -1, 0, 0, -1, 0, 0, 1'b0, -1);
    // F5: right-edge sprite, no wrap to x=0..23; click on frame_start cycle
    run_frame(2032, 0, 56, 4, 2040, 0, 2040, -1, 2044, 2, -1, 0, 0, 1'b1, -1);
    // F6: scanned; click while scanning is dropped
    run_frame(2032, 0, 56, 4, 2040, 0, 2040, 100, 5, 1, -1, 0, 0, 1'b0, -1);
    // F7: click again at (105,55)
    run_frame(96, 48, 40, 11, 100, 50, 100, 289, 105, 55, -1, 0, 0, 1'b0, -1);
    // F8: reset in the middle of the scan -> no result pulse
    run_frame(96, 48, 40, 11, 100, 50, 100, -1, 0, 0, -1, 0, 0, 1'b0, 300);
    run_frame(96, 48, 40, 11, 100, 50, 100, -1, 0, 0, -1, 0, 0, 1'b0, -1);

    // random frames, geometry held for pairs so clicks can land on the sprite
    fx0 = 0; fy0 = 0; sx = 0; sy = 0;
    for (int f = 0; f < 12; f++) begin
      if (f % 2 == 0) begin
        fx0 = int'($urandom_range(XMAX-1, 0));
        fy0 = int'($urandom_range(1950, 0));
        sx  = (fx0 + int'($urandom_range(32, 0)) - 16 + XMAX) % XMAX;
        sy  = fy0 + int'($urandom_range(24, 0)) - 16;
        if (sy < 0) sy = 0;
        if (sy > 2015) sy = 2015;
        for (int a = 0; a < SPR_DIM*SPR_DIM; a++) mem[a] = DATA_W'($urandom_range(3, 0));
        pal1 = RGB_W'($urandom); pal2 = RGB_W'($urandom); pal3 = RGB_W'($urandom);
      end
      mid = ($urandom_range(1, 0) == 0) ? sx : (sx + int'($urandom_range(40, 1))) % XMAX;
      c1i = ($urandom_range(1, 0) == 0) ? int'($urandom_range(32*24-1, 0)) : -1;
      c2i = ($urandom_range(2, 0) == 0) ? int'($urandom_range(32*24-1, 0)) : -1;
      c1x = (fx0 + int'($urandom_range(31, 0))) % XMAX;
      c1y = fy0 + int'($urandom_range(23, 0));
      c2x = (fx0 + int'($urandom_range(31, 0))) % XMAX;
      c2y = fy0 + int'($urandom_range(23, 0));
      cfs = ($urandom_range(5, 0) == 0);
      run_frame(fx0, fy0, 32, 24, sx, sy, (f % 2 == 0) ? sx : mid,
                c1i, c1x, c1y, c2i, c2x, c2y, cfs, -1);
    end

    // flush any pending click result
    run_frame(0, 1000, 4, 2, 500, 500, 500, -1, 0, 0, -1, 0, 0, 1'b0, -1);
    run_frame(0, 1000, 4, 2, 500, 500, 500, -1, 0, 0, -1, 0, 0, 1'b0, -1);

    for (int i = 0; i < 10 && (aq.size() + pq.size() + hq.size()) > 0; i++) step();
    checks++;
    if ((aq.size() + pq.size() + hq.size()) != 0) begin
      fails++;
      $display("FAIL drain got %0d pending exp 0", aq.size() + pq.size() + hq.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
